// File: rtl/func_host_if.sv
// Signal bundle between func_host, its command source, the func core and the result sink.
// master = func_host view; slave = the surrounding environment's view.
interface func_host_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_a_i;
  logic [7:0]  cmd_b_i;
  logic [7:0]  core_a_o;
  logic [7:0]  core_b_o;
  logic        core_in_ready_o;
  logic        core_out_ready_i;
  logic [23:0] core_out_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [23:0] res_data_o;
  logic [7:0]  res_tag_o;

  modport master (
    input  cmd_valid_i, cmd_a_i, cmd_b_i, core_out_ready_i, core_out_i, res_ready_i,
    output cmd_ready_o, core_a_o, core_b_o, core_in_ready_o, res_valid_o, res_data_o, res_tag_o
  );

  modport slave (
    output cmd_valid_i, cmd_a_i, cmd_b_i, core_out_ready_i, core_out_i, res_ready_i,
    input  cmd_ready_o, core_a_o, core_b_o, core_in_ready_o, res_valid_o, res_data_o, res_tag_o
  );
endinterface

// File: rtl/func_host.sv
// Initiator for the func core: buffers (a, b) pairs, issues one at a time, returns tagged results.
// Define FUNC_HOST_CHECK_EN to add an internal a*b + b^3 model that flags core mismatches.
module func_host #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  func_host_if.master bus,
  input  logic        err_clr_i,
  output logic        err_timeout_o,
  output logic        mismatch_o
);
  // state     | meaning
  // IDLE      | waiting for a buffered command and a free result slot
  // ISSUE     | core_in_ready_o strobe, wait counter cleared
  // WAIT_LOW  | waiting for the core to drop its stale out_ready
  // WAIT_HIGH | waiting for out_ready to rise with the new result

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;
  state_t state, state_nxt;

  logic [7:0]    fifo_a   [DEPTH];
  logic [7:0]    fifo_b   [DEPTH];
  logic [7:0]    fifo_tag [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    tag_cnt;
  logic [7:0]    cur_tag;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_inc;
  logic          push, pop, capture, expire, slot_free, timed_out;

  assign bus.cmd_ready_o     = (count != (AW+1)'(DEPTH));
  assign push                = bus.cmd_valid_i & bus.cmd_ready_o;
  assign slot_free           = !bus.res_valid_o | bus.res_ready_i;
  assign wait_inc            = wait_cnt + CW'(1);
  assign timed_out           = (TIMEOUT != 0) && (wait_inc == CW'(TIMEOUT));
  assign bus.core_in_ready_o = (state == ISSUE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Completion is tested before expiry so a result arriving on the last cycle is kept.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && slot_free) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_LOW;
      WAIT_LOW: begin
        if (timed_out) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end else if (!bus.core_out_ready_i) begin
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (bus.core_out_ready_i) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (timed_out) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_a[i]   <= '0;
        fifo_b[i]   <= '0;
        fifo_tag[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_a[wr_ptr]   <= bus.cmd_a_i;
        fifo_b[wr_ptr]   <= bus.cmd_b_i;
        fifo_tag[wr_ptr] <= tag_cnt;
        wr_ptr           <= wr_ptr + AW'(1);
        tag_cnt          <= tag_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.core_a_o <= '0;
      bus.core_b_o <= '0;
      cur_tag      <= '0;
      wait_cnt     <= '0;
    end else begin
      if (pop) begin
        bus.core_a_o <= fifo_a[rd_ptr];
        bus.core_b_o <= fifo_b[rd_ptr];
        cur_tag      <= fifo_tag[rd_ptr];
      end
      if (state == ISSUE)                              wait_cnt <= '0;
      else if (state == WAIT_LOW || state == WAIT_HIGH) wait_cnt <= wait_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.res_valid_o <= 1'b0;
      bus.res_data_o  <= '0;
      bus.res_tag_o   <= '0;
    end else if (capture) begin
      bus.res_valid_o <= 1'b1;
      bus.res_data_o  <= bus.core_out_i;
      bus.res_tag_o   <= cur_tag;
    end else if (bus.res_valid_o && bus.res_ready_i) begin
      bus.res_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)         err_timeout_o <= 1'b0;
    else if (expire)    err_timeout_o <= 1'b1;
    else if (err_clr_i) err_timeout_o <= 1'b0;
  end

`ifdef FUNC_HOST_CHECK_EN
  logic [23:0] model;
  assign model = 24'(bus.core_a_o) * 24'(bus.core_b_o)
               + 24'(bus.core_b_o) * 24'(bus.core_b_o) * 24'(bus.core_b_o);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                   mismatch_o <= 1'b0;
    else if (capture && (model != bus.core_out_i)) mismatch_o <= 1'b1;
    else if (err_clr_i)                           mismatch_o <= 1'b0;
  end
`else
  assign mismatch_o = 1'b0;
`endif
endmodule

// File: tb/tb_func_host.sv
// Directed bench for func_host: a behavioural core responder, a command/result scoreboard
// checked every cycle, and literal expectations for the documented scenarios.
module tb_func_host;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic clk_i = 1'b0;
  logic rst_i;
  logic err_clr_i;
  logic err_timeout_o;
  logic mismatch_o;

  func_host_if bus();

  func_host #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .err_clr_i    (err_clr_i),
    .err_timeout_o(err_timeout_o),
    .mismatch_o   (mismatch_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [7:0] a; logic [7:0] b; logic [7:0] tag; } cmd_t;
  typedef struct packed { logic [23:0] data; logic [7:0] tag; } res_t;

  int n_checks = 0;
  int n_fail   = 0;
  cmd_t cmd_q[$];
  res_t exp_q[$];
  int   n_push = 0, n_issue = 0, n_result = 0;
  logic [7:0]  tag_model = 8'd0;
  logic [23:0] last_data = '0;
  logic [7:0]  last_tag  = '0;
  int  resp_delay = 5;
  bit  resp_hang  = 1'b0;
  bit  resp_wrong = 1'b0;

  function automatic logic [23:0] f_model(input logic [7:0] a, input logic [7:0] b);
    int unsigned r;
    r = int'(a) * int'(b) + int'(b) * int'(b) * int'(b);
    return r[23:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: required event not seen", name);
  endtask

  // Core: drops out_ready one cycle after the request, raises it with the result resp_delay cycles after.
  logic [7:0] rsp_a, rsp_b;
  bit         rsp_hang, rsp_wrong;
  int         rsp_d;
  initial begin
    bus.core_out_ready_i = 1'b0;
    bus.core_out_i       = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i && bus.core_in_ready_o) begin
        rsp_a = bus.core_a_o; rsp_b = bus.core_b_o;
        rsp_hang = resp_hang; rsp_wrong = resp_wrong; rsp_d = resp_delay;
        @(negedge clk_i);
        bus.core_out_ready_i = 1'b0;
        if (!rsp_hang) begin
          repeat (rsp_d - 1) @(negedge clk_i);
          bus.core_out_i       = rsp_wrong ? 24'd13 : f_model(rsp_a, rsp_b);
          bus.core_out_ready_i = 1'b1;
        end
      end
    end
  end

  // Scoreboard, evaluated every cycle out of reset.
  bit          prev_in_ready = 1'b0;
  bit          prev_hold     = 1'b0;
  logic [23:0] prev_data;
  logic [7:0]  prev_tag;
  cmd_t        cmp_c;
  res_t        cmp_r;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_in_ready = 1'b0;
      prev_hold     = 1'b0;
    end else begin
      if (bus.core_in_ready_o) begin
        chk("in_ready_single_cycle", 32'(prev_in_ready), 32'd0);
        n_issue++;
        if (cmd_q.size() == 0) note_fail("issue_with_empty_queue");
        else begin
          cmp_c = cmd_q.pop_front();
          chk("core_a", 32'(bus.core_a_o), 32'(cmp_c.a));
          chk("core_b", 32'(bus.core_b_o), 32'(cmp_c.b));
          if (!resp_hang)
            exp_q.push_back('{resp_wrong ? 24'd13 : f_model(cmp_c.a, cmp_c.b), cmp_c.tag});
        end
      end
      prev_in_ready = bus.core_in_ready_o;
      chk("cmd_ready", 32'(bus.cmd_ready_o), 32'((n_push - n_issue) != DEPTH));
      if (prev_hold) begin
        chk("res_held_valid", 32'(bus.res_valid_o), 32'd1);
        chk("res_held_data", 32'(bus.res_data_o), 32'(prev_data));
        chk("res_held_tag", 32'(bus.res_tag_o), 32'(prev_tag));
      end
      if (bus.res_valid_o && bus.res_ready_i) begin
        if (exp_q.size() == 0) note_fail("unexpected_result");
        else begin
          cmp_r = exp_q.pop_front();
          chk("res_data", 32'(bus.res_data_o), 32'(cmp_r.data));
          chk("res_tag", 32'(bus.res_tag_o), 32'(cmp_r.tag));
        end
        last_data = bus.res_data_o;
        last_tag  = bus.res_tag_o;
        n_result++;
      end
      prev_hold = bus.res_valid_o && !bus.res_ready_i;
      prev_data = bus.res_data_o;
      prev_tag  = bus.res_tag_o;
    end
  end

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, output int stalls);
    stalls = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_a_i     = a;
    bus.cmd_b_i     = b;
    @(posedge clk_i);
    while (!bus.cmd_ready_o && stalls < 300) begin
      stalls++;
      @(posedge clk_i);
    end
    if (bus.cmd_ready_o) begin
      cmd_q.push_back('{a, b, tag_model});
      tag_model++;
      n_push++;
    end else begin
      note_fail("cmd_accept_timeout");
    end
    #1 bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    @(negedge clk_i);
    while (!bus.core_in_ready_o && n < 200) begin
      n++;
      @(negedge clk_i);
    end
    if (!bus.core_in_ready_o) note_fail("issue_timeout");
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk_i);
    while ((cmd_q.size() != 0 || exp_q.size() != 0 || bus.res_valid_o) && n < 600) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 600) note_fail("drain_timeout");
  endtask

  int st, total_st, snap;
  logic exp_mm;
  initial begin
    rst_i = 1'b0; err_clr_i = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_a_i = '0; bus.cmd_b_i = '0; bus.res_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
    chk("rst_in_ready", 32'(bus.core_in_ready_o), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("rst_err", 32'(err_timeout_o), 32'd0);
    rst_i = 1'b1;

    // Single command, core answers after 5 wait cycles.
    push_cmd(8'd3, 8'd2, st);
    wait_issue();
    chk("t1_core_a", 32'(bus.core_a_o), 32'd3);
    chk("t1_core_b", 32'(bus.core_b_o), 32'd2);
    wait_drain();
    chk("t1_data", 32'(last_data), 32'd14);
    chk("t1_tag", 32'(last_tag), 32'd0);

    // Largest operands.
    push_cmd(8'd255, 8'd255, st);
    wait_drain();
    chk("t2_data", 32'(last_data), 32'hFE0100);
    chk("t2_tag", 32'(last_tag), 32'd1);

    // Six back-to-back commands overflow the 4-entry buffer.
    snap = n_result;
    total_st = 0;
    for (int i = 0; i < 6; i++) begin
      push_cmd(8'(i + 4), 8'(2 * i + 1), st);
      total_st += st;
    end
    wait_drain();
    chk("t3_backpressure_seen", 32'(total_st > 0), 32'd1);
    chk("t3_result_count", 32'(n_result - snap), 32'd6);
    chk("t3_last_data", 32'(last_data), 32'(9 * 11 + 11 * 11 * 11));
    chk("t3_last_tag", 32'(last_tag), 32'd7);

    // Result slot full: the second command must not issue.
    @(posedge clk_i); #1 bus.res_ready_i = 1'b0;
    push_cmd(8'd10, 8'd20, st);
    push_cmd(8'd30, 8'd40, st);
    snap = 0;
    while (!bus.res_valid_o && snap < 100) begin @(negedge clk_i); snap++; end
    snap = n_issue;
    repeat (20) @(negedge clk_i);
    chk("t4_second_issue_withheld", 32'(n_issue - snap), 32'd0);
    chk("t4_held_data", 32'(bus.res_data_o), 32'd8200);
    chk("t4_held_tag", 32'(bus.res_tag_o), 32'd8);
    @(posedge clk_i); #1 bus.res_ready_i = 1'b1;
    wait_drain();
    chk("t4_second_data", 32'(last_data), 32'd65200);
    chk("t4_second_tag", 32'(last_tag), 32'd9);

    // Hung core: watchdog fires after TIMEOUT wait cycles, transaction dropped.
    resp_hang = 1'b1;
    push_cmd(8'd7, 8'd9, st);
    wait_issue();
    repeat (TIMEOUT) @(negedge clk_i);
    chk("t5_err_not_yet", 32'(err_timeout_o), 32'd0);
    @(negedge clk_i);
    chk("t5_err_set", 32'(err_timeout_o), 32'd1);
    chk("t5_no_result", 32'(bus.res_valid_o), 32'd0);
    resp_hang = 1'b0;
    push_cmd(8'd1, 8'd1, st);
    wait_drain();
    chk("t5_next_data", 32'(last_data), 32'd2);
    chk("t5_next_tag", 32'(last_tag), 32'd11);
    chk("t5_err_sticky", 32'(err_timeout_o), 32'd1);
    @(posedge clk_i); #1 err_clr_i = 1'b1;
    @(posedge clk_i); #1 err_clr_i = 1'b0;
    @(negedge clk_i);
    chk("t5_err_cleared", 32'(err_timeout_o), 32'd0);

    // Reset during WAIT_HIGH abandons the transaction.
    resp_delay = 6;
    push_cmd(8'd5, 8'd6, st);
    wait_issue();
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_in_ready", 32'(bus.core_in_ready_o), 32'd0);
    chk("t6_core_a", 32'(bus.core_a_o), 32'd0);
    chk("t6_core_b", 32'(bus.core_b_o), 32'd0);
    chk("t6_res_valid", 32'(bus.res_valid_o), 32'd0);
    chk("t6_res_data", 32'(bus.res_data_o), 32'd0);
    chk("t6_res_tag", 32'(bus.res_tag_o), 32'd0);
    chk("t6_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    cmd_q.delete(); exp_q.delete();
    n_push = 0; n_issue = 0; tag_model = 8'd0;
    repeat (4) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Wrong core answer: delivered as is, tag restarts at 0.
    resp_delay = 5; resp_wrong = 1'b1;
    push_cmd(8'd3, 8'd2, st);
    wait_drain();
    resp_wrong = 1'b0;
    chk("t7_data", 32'(last_data), 32'd13);
    chk("t7_tag", 32'(last_tag), 32'd0);
`ifdef FUNC_HOST_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    chk("t7_mismatch", 32'(mismatch_o), 32'(exp_mm));
    @(posedge clk_i); #1 err_clr_i = 1'b1;
    @(posedge clk_i); #1 err_clr_i = 1'b0;
    @(negedge clk_i);
    chk("t7_mismatch_cleared", 32'(mismatch_o), 32'd0);

    chk("end_cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
    chk("end_exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
